// File: rtl/state_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : state_seq_ctrl
// Description : Sequences the shared 2-bit state and 1-bit data registers
//               through DRIVE_LO/DRIVE_HI/HOLD with a programmable dwell.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module state_seq_ctrl #(
    parameter int DWELL_W       = 8,
    parameter int DEFAULT_DWELL = 4,
    parameter int RUN_W         = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               cfg_load,
    input  logic [DWELL_W-1:0] dwell_cfg,
    output logic [1:0]         state,
    output logic               data,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [RUN_W-1:0]   run_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b01,
        S_DRIVE_LO = 2'b00,
        S_DRIVE_HI = 2'b10,
        S_HOLD     = 2'b11
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_data;
    logic               w_data_nxt;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic               r_aborted;
    logic               w_aborted_nxt;
    logic [RUN_W-1:0]   r_run_cnt;
    logic [RUN_W-1:0]   w_run_cnt_nxt;

    logic               w_cfg_take;
    logic [DWELL_W-1:0] w_dwell_src;
    logic [DWELL_W-1:0] w_reload;

    // A load coinciding with start must already govern the first phase.
    assign w_cfg_take  = (r_state == S_IDLE) && cfg_load;
    assign w_dwell_src = w_cfg_take ? dwell_cfg : r_dwell;
    assign w_reload    = (w_dwell_src == '0) ? '0 : (w_dwell_src - DWELL_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_data    <= 1'b0;
            r_dwell   <= DWELL_W'(DEFAULT_DWELL);
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_data    <= w_data_nxt;
            r_dwell   <= w_dwell_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
            r_run_cnt <= w_run_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_dwell_nxt   = w_dwell_src;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_run_cnt_nxt = r_run_cnt;

        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = S_DRIVE_LO;
                    w_data_nxt  = 1'b0;
                    w_cnt_nxt   = w_reload;
                end
            end
            S_DRIVE_LO, S_DRIVE_HI, S_HOLD: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_data_nxt    = 1'b0;
                    w_cnt_nxt     = '0;
                    w_aborted_nxt = 1'b1;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - DWELL_W'(1);
                end else begin
                    w_cnt_nxt = w_reload;
                    case (r_state)
                        S_DRIVE_LO: begin
                            w_state_nxt = S_DRIVE_HI;
                            w_data_nxt  = 1'b1;
                        end
                        S_DRIVE_HI: begin
                            w_state_nxt = S_HOLD;
                        end
                        default: begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                            w_done_nxt  = 1'b1;
                            if (r_run_cnt != '1)
                                w_run_cnt_nxt = r_run_cnt + RUN_W'(1);
                        end
                    endcase
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign state     = r_state;
    assign data      = r_data;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign aborted   = r_aborted;
    assign run_count = r_run_cnt;

endmodule

`default_nettype wire

// File: tb/tb_state_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_state_seq_ctrl
// Description : Directed self-checking bench for state_seq_ctrl.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_state_seq_ctrl;

    localparam int c_DWELL_W = 8;
    localparam int c_RUN_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 cfg_load = 1'b0;
    logic [c_DWELL_W-1:0] dwell_cfg = '0;
    logic [1:0]           state;
    logic                 data;
    logic                 busy;
    logic                 done;
    logic                 aborted;
    logic [c_RUN_W-1:0]   run_count;

    int n_cmp = 0;
    int n_err = 0;

    state_seq_ctrl #(
        .DWELL_W      (c_DWELL_W),
        .DEFAULT_DWELL(4),
        .RUN_W        (c_RUN_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cfg_load (cfg_load),
        .dwell_cfg(dwell_cfg),
        .state    (state),
        .data     (data),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted),
        .run_count(run_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    // Expected phase code for cycle k (1-based) of a run with dwell d.
    function automatic int exp_state(input int k, input int d);
        if (k <= d)        return 0;
        else if (k <= 2*d) return 2;
        else if (k <= 3*d) return 3;
        else               return 1;
    endfunction

    int exp_rc;

    initial begin
        // Reset state
        repeat (2) next_cyc();
        rst = 1'b0;
        next_cyc();
        check_val("rst_state", state, 1);
        check_val("rst_data", data, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_aborted", aborted, 0);
        check_val("rst_runcnt", run_count, 0);

        // Default dwell run: 12 busy cycles, done at cycle 13
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            check_val($sformatf("def_state_c%0d", k), state, exp_state(k, 4));
            check_val($sformatf("def_data_c%0d", k), data, (k <= 4) ? 0 : 1);
            check_val($sformatf("def_busy_c%0d", k), busy, 1);
            check_val($sformatf("def_done_c%0d", k), done, 0);
            next_cyc();
        end
        check_val("def_end_state", state, 1);
        check_val("def_end_done", done, 1);
        check_val("def_end_data", data, 1);
        check_val("def_end_runcnt", run_count, 1);
        next_cyc();
        check_val("def_done_pulse", done, 0);

        // dwell_cfg=0 loaded with start: one cycle per phase
        cfg_load = 1'b1; dwell_cfg = 8'd0; start = 1'b1;
        next_cyc();
        cfg_load = 1'b0; start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check_val($sformatf("d0_state_c%0d", k), state, exp_state(k, 1));
            check_val($sformatf("d0_busy_c%0d", k), busy, 1);
            next_cyc();
        end
        check_val("d0_end_state", state, 1);
        check_val("d0_end_done", done, 1);
        check_val("d0_end_runcnt", run_count, 2);
        next_cyc();

        // dwell 2, abort on second DRIVE_HI cycle
        cfg_load = 1'b1; dwell_cfg = 8'd2;
        next_cyc();
        cfg_load = 1'b0; start = 1'b1;
        next_cyc();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            check_val($sformatf("ab_state_c%0d", k), state, exp_state(k, 2));
            check_val($sformatf("ab_done_c%0d", k), done, 0);
            if (k == 4) abort = 1'b1;
            next_cyc();
        end
        abort = 1'b0;
        check_val("ab_state", state, 1);
        check_val("ab_data", data, 0);
        check_val("ab_aborted", aborted, 1);
        check_val("ab_done", done, 0);
        check_val("ab_runcnt", run_count, 2);
        next_cyc();
        check_val("ab_pulse", aborted, 0);
        check_val("ab_done2", done, 0);

        // abort together with start in IDLE: stays IDLE
        start = 1'b1; abort = 1'b1;
        next_cyc();
        start = 1'b0; abort = 1'b0;
        check_val("sa_state", state, 1);
        check_val("sa_aborted", aborted, 0);

        // 17 back-to-back dwell-1 runs; cfg_load while busy ignored
        cfg_load = 1'b1; dwell_cfg = 8'd1;
        next_cyc();
        cfg_load = 1'b0;
        exp_rc = 2;
        start = 1'b1;
        next_cyc();
        for (int r = 1; r <= 17; r++) begin
            check_val($sformatf("bb%0d_s1", r), state, 0);
            cfg_load = 1'b1; dwell_cfg = 8'd5;
            next_cyc();
            cfg_load = 1'b0;
            check_val($sformatf("bb%0d_s2", r), state, 2);
            next_cyc();
            check_val($sformatf("bb%0d_s3", r), state, 3);
            next_cyc();
            exp_rc = (exp_rc < 15) ? exp_rc + 1 : 15;
            check_val($sformatf("bb%0d_idle", r), state, 1);
            check_val($sformatf("bb%0d_done", r), done, 1);
            check_val($sformatf("bb%0d_runcnt", r), run_count, exp_rc);
            if (r == 17) start = 1'b0;
            next_cyc();
        end
        check_val("bb_final_state", state, 1);
        check_val("bb_final_runcnt", run_count, 15);

        // Asynchronous reset mid-HOLD (dwell 3: HOLD is cycles 7-9)
        cfg_load = 1'b1; dwell_cfg = 8'd3; start = 1'b1;
        next_cyc();
        cfg_load = 1'b0; start = 1'b0;
        for (int k = 1; k < 8; k++) next_cyc();
        check_val("rh_pre_state", state, 3);
        #2 rst = 1'b1;
        #1;
        check_val("rh_state", state, 1);
        check_val("rh_data", data, 0);
        check_val("rh_busy", busy, 0);
        check_val("rh_runcnt", run_count, 0);
        check_val("rh_done", done, 0);
        next_cyc();
        rst = 1'b0;
        next_cyc();
        check_val("rh_post_done", done, 0);
        check_val("rh_post_aborted", aborted, 0);
        check_val("rh_post_state", state, 1);

        // Dwell register back to its reset default of 4
        start = 1'b1;
        next_cyc();
        start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            check_val($sformatf("rd_state_c%0d", k), state, exp_state(k, 4));
            next_cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
